// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among N requesters: registered one-hot grant,
// rotating priority pointer, and a hold-timeout that reclaims the ALU from a stalled owner.
module alu_rr_arbiter #(
    parameter int N       = 16,
    parameter int MAXHOLD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [3:0]   gnt_id,
    output logic         timeout
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] MAXH = 8'(MAXHOLD);

    state_t       state, state_nx;
    logic [3:0]   ptr, ptr_nx;
    logic [7:0]   hold_cnt, cnt_nx;
    logic [N-1:0] gnt_nx;
    logic [3:0]   gnt_id_nx;
    logic         timeout_nx;
    logic         pick_vld;
    logic [3:0]   pick_id;
    logic         rel_done, rel_wd, rel_to;

    // Scan starts at p and descends with wrap; bit 4 of the result flags a winner.
    function automatic logic [4:0] rr_pick(input logic [N-1:0] r, input logic [3:0] p);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int i = 0; i < N; i++) begin
            idx = p - 4'(i);
            if (!res[4] && r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == MAXH) ? v : v + 8'd1;
    endfunction

    assign {pick_vld, pick_id} = rr_pick(req, ptr);

    assign rel_done = done;
    assign rel_wd   = !req[gnt_id];
    assign rel_to   = (hold_cnt == MAXH);

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        cnt_nx     = hold_cnt;
        gnt_nx     = gnt;
        gnt_id_nx  = gnt_id;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_nx          = '0;
                    gnt_nx[pick_id] = 1'b1;
                    gnt_id_nx       = pick_id;
                    ptr_nx          = pick_id - 4'd1;
                    cnt_nx          = 8'd1;
                    state_nx        = HOLD;
                end
            end
            HOLD: begin
                if (rel_done || rel_wd || rel_to) begin
                    // done and withdrawal outrank the timeout, so they suppress the pulse
                    timeout_nx = rel_to && !rel_done && !rel_wd;
                    if (pick_vld) begin
                        gnt_nx          = '0;
                        gnt_nx[pick_id] = 1'b1;
                        gnt_id_nx       = pick_id;
                        ptr_nx          = pick_id - 4'd1;
                        cnt_nx          = 8'd1;
                    end else begin
                        gnt_nx    = '0;
                        gnt_id_nx = 4'd0;
                        cnt_nx    = 8'd0;
                        state_nx  = IDLE;
                    end
                end else begin
                    cnt_nx = sat_inc(hold_cnt);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 4'd15;
            hold_cnt <= 8'd0;
            gnt      <= '0;
            gnt_id   <= 4'd0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold_cnt <= cnt_nx;
            gnt      <= gnt_nx;
            gnt_id   <= gnt_id_nx;
            timeout  <= timeout_nx;
        end
    end

    assign gnt_valid = |gnt;

endmodule
